// File: rtl/spi_xip_pkg.sv
// -----------------------------------------------------------------------------
// spi_xip_pkg
// Shared definitions for the APB-to-SPI-master XIP bridge: register offsets of
// the Wishbone SPI master, the flash read opcode, the CTRL word that launches a
// 64-bit transfer, the controller state enum and a byte-swap helper.
// -----------------------------------------------------------------------------
package spi_xip_pkg;

    // SPI master register offsets (RX0 and TX0 share the same offset)
    localparam logic [4:0]  REG_RX0     = 5'h00;
    localparam logic [4:0]  REG_TX0     = 5'h00;
    localparam logic [4:0]  REG_TX1     = 5'h04;
    localparam logic [4:0]  REG_CTRL    = 5'h10;
    localparam logic [4:0]  REG_DIVIDER = 5'h14;
    localparam logic [4:0]  REG_SS      = 5'h18;

    localparam logic [7:0]  FLASH_READ_OP = 8'h03;

    // ASS | GO_BSY | CHAR_LEN=64 (encoded as 0x40)
    localparam logic [31:0] CTRL_GO       = 32'h0000_2140;
    localparam int unsigned CTRL_BSY_BIT  = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PASS,
        ST_W_TX1,
        ST_W_TX0,
        ST_W_DIV,
        ST_W_SS,
        ST_W_CTRL,
        ST_POLL,
        ST_RD_RX,
        ST_CLR_SS,
        ST_RESP
    } xip_state_e;

    // One Wishbone request as issued by a sequencing state
    typedef struct packed {
        logic [4:0]  adr;
        logic [31:0] dat;
        logic        we;
    } wb_req_t;

    // The flash returns the addressed byte in the top lane of RX0
    function automatic logic [31:0] byte_swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/spi_xip_ctrl.sv
// -----------------------------------------------------------------------------
// spi_xip_ctrl
// APB slave that either passes accesses straight through to a Wishbone SPI
// master (register window) or turns an APB read in the flash window into a
// complete SPI flash READ (0x03) sequence on that master (execute-in-place).
//
// Ports
//   clock, reset      : sole clock; asynchronous active-high reset
//   in_p*             : APB slave side; in_pready pulses for one cycle per
//                       accepted request, in_prdata/in_pslverr valid with it
//   wb_*              : Wishbone master towards the SPI master registers
//
// Every Wishbone step holds cyc/stb until ack (or err), drops them for the
// cycle after, and only then does the next step raise them again.
// -----------------------------------------------------------------------------
module spi_xip_ctrl
    import spi_xip_pkg::*;
#(
    parameter logic [31:0] FLASH_BASE = 32'h3000_0000,
    parameter logic [31:0] FLASH_END  = 32'h3fff_ffff,
    parameter logic [31:0] SPI_BASE   = 32'h1000_1000,
    parameter logic [31:0] SPI_END    = 32'h1000_1fff,
    parameter logic [31:0] DIVIDER    = 32'h0000_0001,
    parameter logic [7:0]  SS_MASK    = 8'h01,
    parameter int unsigned POLL_MAX   = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_paddr,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic        in_pwrite,
    input  logic [31:0] in_pwdata,
    input  logic [3:0]  in_pstrb,
    output logic        in_pready,
    output logic [31:0] in_prdata,
    output logic        in_pslverr,
    output logic [4:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam logic [31:0] POLL_LAST = 32'(POLL_MAX - 1);

    xip_state_e  state_q, state_n;

    // request context (data path, not reset)
    logic [23:0] addr_q, addr_n;
    logic [31:0] wdata_q, wdata_n;
    logic [3:0]  strb_q, strb_n;
    logic        write_q, write_n;
    logic [31:0] rdata_q, rdata_n;

    // control
    logic        err_q, err_n;
    logic [31:0] poll_q, poll_n;

    // next values of the registered outputs
    logic        cyc_n, stb_n, we_n;
    logic [4:0]  adr_n;
    logic [31:0] dat_n;
    logic [3:0]  sel_n;
    logic        pready_n;
    logic [31:0] prdata_n;
    logic        pslverr_n;

    logic        hit_spi, hit_flash;
    wb_req_t     req;

    assign hit_spi   = (in_paddr >= SPI_BASE)   && (in_paddr <= SPI_END);
    assign hit_flash = (in_paddr >= FLASH_BASE) && (in_paddr <= FLASH_END);

    // Address, data and direction each sequencing state puts on the bus
    function automatic wb_req_t step_req(input xip_state_e  st,
                                         input logic [23:0] a,
                                         input logic [31:0] wd,
                                         input logic        wr);
        wb_req_t r;
        r.adr = REG_CTRL;
        r.dat = '0;
        r.we  = 1'b0;
        case (st)
            ST_PASS:   begin r.adr = a[4:0];      r.dat = wd;                   r.we = wr;   end
            ST_W_TX1:  begin r.adr = REG_TX1;     r.dat = {FLASH_READ_OP, a};   r.we = 1'b1; end
            ST_W_TX0:  begin r.adr = REG_TX0;     r.dat = '0;                   r.we = 1'b1; end
            ST_W_DIV:  begin r.adr = REG_DIVIDER; r.dat = DIVIDER;              r.we = 1'b1; end
            ST_W_SS:   begin r.adr = REG_SS;      r.dat = {24'h0, SS_MASK};     r.we = 1'b1; end
            ST_W_CTRL: begin r.adr = REG_CTRL;    r.dat = CTRL_GO;              r.we = 1'b1; end
            ST_POLL:   begin r.adr = REG_CTRL;    r.dat = '0;                   r.we = 1'b0; end
            ST_RD_RX:  begin r.adr = REG_RX0;     r.dat = '0;                   r.we = 1'b0; end
            ST_CLR_SS: begin r.adr = REG_SS;      r.dat = '0;                   r.we = 1'b1; end
            default:   ;
        endcase
        return r;
    endfunction

    // Once slave-select has been written, an abort must still release it
    function automatic logic past_ss(input xip_state_e st);
        return (st == ST_W_CTRL) || (st == ST_POLL) || (st == ST_RD_RX);
    endfunction

    always_comb begin
        state_n = state_q;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        strb_n  = strb_q;
        write_n = write_q;
        rdata_n = rdata_q;
        err_n   = err_q;
        poll_n  = poll_q;
        cyc_n   = wb_cyc_o;
        stb_n   = wb_stb_o;
        adr_n   = wb_adr_o;
        dat_n   = wb_dat_o;
        sel_n   = wb_sel_o;
        we_n    = wb_we_o;
        req     = step_req(state_q, addr_q, wdata_q, write_q);

        case (state_q)
            ST_IDLE: begin
                if (in_psel && in_penable) begin
                    addr_n  = in_paddr[23:0];
                    wdata_n = in_pwdata;
                    strb_n  = in_pstrb;
                    write_n = in_pwrite;
                    rdata_n = '0;
                    err_n   = 1'b0;
                    if (hit_spi) begin
                        state_n = ST_PASS;
                    end else if (hit_flash && !in_pwrite) begin
                        state_n = ST_W_TX1;
                    end else begin
                        err_n   = 1'b1;
                        state_n = ST_RESP;
                    end
                end
            end

            ST_RESP: state_n = ST_IDLE;

            default: begin
                if (!wb_cyc_o) begin
                    cyc_n = 1'b1;
                    stb_n = 1'b1;
                    adr_n = req.adr;
                    dat_n = req.dat;
                    we_n  = req.we;
                    sel_n = (state_q == ST_PASS) ? strb_q : 4'hf;
                end else if (wb_err_i || wb_ack_i) begin
                    cyc_n = 1'b0;
                    stb_n = 1'b0;
                    adr_n = '0;
                    dat_n = '0;
                    sel_n = '0;
                    we_n  = 1'b0;
                    if (wb_err_i) begin
                        err_n   = 1'b1;
                        rdata_n = '0;
                        state_n = past_ss(state_q) ? ST_CLR_SS : ST_RESP;
                    end else begin
                        case (state_q)
                            ST_PASS: begin
                                if (!write_q) rdata_n = wb_dat_i;
                                state_n = ST_RESP;
                            end
                            ST_W_TX1:  state_n = ST_W_TX0;
                            ST_W_TX0:  state_n = ST_W_DIV;
                            ST_W_DIV:  state_n = ST_W_SS;
                            ST_W_SS:   state_n = ST_W_CTRL;
                            ST_W_CTRL: begin
                                poll_n  = '0;
                                state_n = ST_POLL;
                            end
                            ST_POLL: begin
                                if (!wb_dat_i[CTRL_BSY_BIT]) begin
                                    state_n = ST_RD_RX;
                                end else if (poll_q >= POLL_LAST) begin
                                    err_n   = 1'b1;
                                    rdata_n = '0;
                                    state_n = ST_CLR_SS;
                                end else begin
                                    poll_n = poll_q + 32'd1;
                                end
                            end
                            ST_RD_RX: begin
                                rdata_n = byte_swap(wb_dat_i);
                                state_n = ST_CLR_SS;
                            end
                            ST_CLR_SS: state_n = ST_RESP;
                            default:   state_n = ST_IDLE;
                        endcase
                    end
                end
            end
        endcase

        // APB response outputs are registered and only non-zero in RESP
        pready_n  = (state_n == ST_RESP);
        prdata_n  = pready_n ? rdata_n : '0;
        pslverr_n = pready_n & err_n;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            err_q      <= 1'b0;
            poll_q     <= '0;
            in_pready  <= 1'b0;
            in_prdata  <= '0;
            in_pslverr <= 1'b0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_sel_o   <= '0;
            wb_we_o    <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_cyc_o   <= 1'b0;
        end else begin
            state_q    <= state_n;
            err_q      <= err_n;
            poll_q     <= poll_n;
            in_pready  <= pready_n;
            in_prdata  <= prdata_n;
            in_pslverr <= pslverr_n;
            wb_adr_o   <= adr_n;
            wb_dat_o   <= dat_n;
            wb_sel_o   <= sel_n;
            wb_we_o    <= we_n;
            wb_stb_o   <= stb_n;
            wb_cyc_o   <= cyc_n;
        end
    end

    always_ff @(posedge clock) begin
        addr_q  <= addr_n;
        wdata_q <= wdata_n;
        strb_q  <= strb_n;
        write_q <= write_n;
        rdata_q <= rdata_n;
    end

endmodule

// File: tb/tb_spi_xip_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_xip_ctrl
// Random and directed APB traffic against spi_xip_ctrl. For every request the
// bench writes down, from the bridge's rules, the exact list of Wishbone steps
// it must see (with the slave's reply for each) and the APB response; a single
// negedge process plays the Wishbone slave from that list and checks the DUT.
// -----------------------------------------------------------------------------
module tb_spi_xip_ctrl;

    localparam int unsigned POLL_MAX = 4;
    localparam logic [31:0] DIVIDER  = 32'h0000_0001;
    localparam logic [7:0]  SS_MASK  = 8'h01;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_paddr = '0;
    logic        in_psel = 1'b0;
    logic        in_penable = 1'b0;
    logic        in_pwrite = 1'b0;
    logic [31:0] in_pwdata = '0;
    logic [3:0]  in_pstrb = '0;
    logic        in_pready;
    logic [31:0] in_prdata;
    logic        in_pslverr;
    logic [4:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;

    spi_xip_ctrl #(.POLL_MAX(POLL_MAX), .DIVIDER(DIVIDER), .SS_MASK(SS_MASK)) dut (
        .clock(clock), .reset(reset),
        .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable),
        .in_pwrite(in_pwrite), .in_pwdata(in_pwdata), .in_pstrb(in_pstrb),
        .in_pready(in_pready), .in_prdata(in_prdata), .in_pslverr(in_pslverr),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o),
        .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clock = ~clock;

    int cyc_cnt = 0;
    always @(posedge clock) cyc_cnt++;

    typedef struct {
        logic [4:0]  adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
        logic        err;
        logic [31:0] rdata;
    } step_t;

    step_t       script[$];
    logic        exp_pending = 1'b0;
    logic        exp_err = 1'b0;
    logic        exp_chk_rd = 1'b0;
    logic [31:0] exp_rd = '0;
    int          last_evt = 0;

    int          checks = 0;
    int          errors = 0;

    // observations of the last transaction for literal checks
    int          obs_wb_cnt, obs_poll_cnt, obs_ctrl_wr, obs_lat;
    logic [31:0] obs_tx1, obs_ss_last, obs_last_adr, obs_last_dat, obs_prdata;
    logic        obs_pslverr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic step_t mk(input logic we, input logic [4:0] adr,
                                 input logic [31:0] dat, input logic [31:0] rd);
        step_t s;
        s.adr = adr; s.dat = dat; s.we = we; s.sel = 4'hf; s.err = 1'b0; s.rdata = rd;
        return s;
    endfunction

    function automatic logic [31:0] swap_model(input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*(3-b) +: 8];
        return r;
    endfunction

    function automatic bit in_window(input logic [31:0] a);
        return ((a >= 32'h1000_1000) && (a <= 32'h1000_1fff)) ||
               ((a >= 32'h3000_0000) && (a <= 32'h3fff_ffff));
    endfunction

    // Flash read: fixed step list, `busy` polls report bit 8 set, optional
    // slave error at step index err_at (-1 for none).
    task automatic plan_xip(input logic [31:0] a, input logic [31:0] word,
                            input int busy, input int err_at);
        step_t q[$];
        step_t s;
        logic [31:0] r;
        int polls;
        bit tmo, clr;
        tmo = (busy >= int'(POLL_MAX));
        q.push_back(mk(1'b1, 5'h04, {8'h03, a[23:0]}, 32'h0));
        q.push_back(mk(1'b1, 5'h00, 32'h0, 32'h0));
        q.push_back(mk(1'b1, 5'h14, DIVIDER, 32'h0));
        q.push_back(mk(1'b1, 5'h18, {24'h0, SS_MASK}, 32'h0));
        q.push_back(mk(1'b1, 5'h10, 32'h0000_2140, 32'h0));
        polls = tmo ? int'(POLL_MAX) : busy + 1;
        for (int i = 0; i < polls; i++) begin
            r = $urandom;
            r[8] = (i < busy);
            q.push_back(mk(1'b0, 5'h10, 32'h0, r));
        end
        if (!tmo) q.push_back(mk(1'b0, 5'h00, 32'h0, word));
        q.push_back(mk(1'b1, 5'h18, 32'h0, 32'h0));
        exp_err = tmo; exp_chk_rd = 1'b1; exp_rd = swap_model(word);
        if (err_at >= 0 && err_at < q.size()) begin
            clr = (err_at >= 4) && (err_at < q.size() - 1);
            while (q.size() > err_at + 1) void'(q.pop_back());
            s = q.pop_back(); s.err = 1'b1; q.push_back(s);
            if (clr) q.push_back(mk(1'b1, 5'h18, 32'h0, 32'h0));
            exp_err = 1'b1;
        end
        script = q;
    endtask

    task automatic plan_pass(input logic [31:0] a, input logic [31:0] d, input logic w,
                             input logic [3:0] s, input logic err);
        step_t e;
        e = mk(w, a[4:0], d, $urandom);
        e.sel = s; e.err = err;
        script.delete();
        script.push_back(e);
        exp_err = err; exp_chk_rd = !w; exp_rd = e.rdata;
    endtask

    task automatic plan_reject();
        script.delete();
        exp_err = 1'b1; exp_chk_rd = 1'b0; exp_rd = '0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        exp_pending = 1'b0;
        repeat (2) @(negedge clock);
        script.delete();
        reset = 1'b0;
    endtask

    task automatic apb_xfer(input logic [31:0] a, input logic [31:0] d, input logic w,
                            input logic [3:0] s);
        int n;
        obs_wb_cnt = 0; obs_poll_cnt = 0; obs_ctrl_wr = 0; obs_lat = -1;
        obs_tx1 = 32'hdead_beef; obs_ss_last = 32'hdead_beef;
        obs_last_adr = '1; obs_last_dat = '1; obs_prdata = '1; obs_pslverr = 1'bx;
        @(negedge clock);
        in_paddr = a; in_pwdata = d; in_pwrite = w; in_pstrb = s;
        in_psel = 1'b1; in_penable = 1'b0;
        @(negedge clock);
        in_penable = 1'b1;
        exp_pending = 1'b1;
        last_evt = cyc_cnt;
        n = 0;
        while (!in_pready && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("apb_done", {31'h0, in_pready}, 32'h1);
        in_psel = 1'b0; in_penable = 1'b0;
        if (!in_pready) pulse_reset();
        #1;
    endtask

    // Compare process and Wishbone slave
    initial begin
        step_t s;
        bit    pending;
        int    wdelay;
        pending = 1'b0;
        wdelay  = 0;
        forever begin
            @(negedge clock);
            if (in_pready) begin
                check("pready_expected", {31'h0, exp_pending}, 32'h1);
                check("pslverr", {31'h0, in_pslverr}, {31'h0, exp_err});
                if (!exp_err && exp_chk_rd) check("prdata", in_prdata, exp_rd);
                check("steps_left", script.size(), 0);
                check("resp_latency", cyc_cnt - last_evt, 1);
                obs_prdata = in_prdata; obs_pslverr = in_pslverr; obs_lat = cyc_cnt - last_evt;
                exp_pending = 1'b0;
            end else begin
                check("prdata_idle", in_prdata, 0);
                check("pslverr_idle", {31'h0, in_pslverr}, 0);
            end

            if (reset) begin
                wb_ack_i = 1'b0; wb_err_i = 1'b0; pending = 1'b0;
            end else if (wb_ack_i || wb_err_i) begin
                wb_ack_i = 1'b0; wb_err_i = 1'b0;
                check("cyc_drop_after_ack", {31'h0, wb_cyc_o}, 0);
            end else if (wb_cyc_o) begin
                if (!pending) begin
                    pending = 1'b1;
                    wdelay  = $urandom_range(0, 2);
                end
                if (wdelay == 0) begin
                    pending = 1'b0;
                    check("stb_with_cyc", {31'h0, wb_stb_o}, 1);
                    check("wb_expected", {31'h0, script.size() != 0}, 1);
                    if (script.size() != 0) begin
                        s = script.pop_front();
                        check("wb_adr", {27'h0, wb_adr_o}, {27'h0, s.adr});
                        check("wb_we", {31'h0, wb_we_o}, {31'h0, s.we});
                        check("wb_sel", {28'h0, wb_sel_o}, {28'h0, s.sel});
                        if (s.we) check("wb_dat", wb_dat_o, s.dat);
                        wb_dat_i = s.we ? $urandom : s.rdata;
                        if (s.err) wb_err_i = 1'b1;
                        else       wb_ack_i = 1'b1;
                    end else begin
                        wb_ack_i = 1'b1;
                    end
                    obs_wb_cnt++;
                    obs_last_adr = {27'h0, wb_adr_o};
                    obs_last_dat = wb_dat_o;
                    if (wb_we_o && wb_adr_o == 5'h04) obs_tx1 = wb_dat_o;
                    if (wb_we_o && wb_adr_o == 5'h18) obs_ss_last = wb_dat_o;
                    if (wb_we_o && wb_adr_o == 5'h10) obs_ctrl_wr++;
                    if (!wb_we_o && wb_adr_o == 5'h10) obs_poll_cnt++;
                    last_evt = cyc_cnt;
                end else begin
                    wdelay--;
                end
            end else if (pending) begin
                check("cyc_held_until_ack", {31'h0, wb_cyc_o}, 1);
                pending = 1'b0;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d, w;
        int kind, found;

        repeat (3) @(negedge clock);
        #1;
        check("rst_pready",  {31'h0, in_pready}, 0);
        check("rst_prdata",  in_prdata, 0);
        check("rst_pslverr", {31'h0, in_pslverr}, 0);
        check("rst_adr",     {27'h0, wb_adr_o}, 0);
        check("rst_dat",     wb_dat_o, 0);
        check("rst_sel",     {28'h0, wb_sel_o}, 0);
        check("rst_we",      {31'h0, wb_we_o}, 0);
        check("rst_stb",     {31'h0, wb_stb_o}, 0);
        check("rst_cyc",     {31'h0, wb_cyc_o}, 0);
        @(negedge clock);
        reset = 1'b0;

        // Flash read with one busy poll
        plan_xip(32'h3000_0104, 32'h1122_3344, 1, -1);
        apb_xfer(32'h3000_0104, 32'h0, 1'b0, 4'h0);
        check("xip_tx1",     obs_tx1, 32'h0300_0104);
        check("xip_prdata",  obs_prdata, 32'h4433_2211);
        check("xip_pslverr", {31'h0, obs_pslverr}, 0);
        check("xip_ss_clr",  obs_ss_last, 32'h0);

        // Register pass-through write
        plan_pass(32'h1000_1014, 32'h5, 1'b1, 4'hf, 1'b0);
        apb_xfer(32'h1000_1014, 32'h5, 1'b1, 4'hf);
        check("pass_wb_cnt", obs_wb_cnt, 1);
        check("pass_adr",    obs_last_adr, 32'h14);
        check("pass_dat",    obs_last_dat, 32'h5);
        check("pass_lat",    obs_lat, 1);

        // Flash write is rejected without bus traffic
        plan_reject();
        apb_xfer(32'h3000_0000, 32'h1234, 1'b1, 4'hf);
        check("xipwr_wb_cnt",  obs_wb_cnt, 0);
        check("xipwr_pslverr", {31'h0, obs_pslverr}, 1);
        check("xipwr_lat",     obs_lat, 1);

        // Busy bit never clears
        plan_xip(32'h3000_0200, 32'hcafe_f00d, 10, -1);
        apb_xfer(32'h3000_0200, 32'h0, 1'b0, 4'h0);
        check("tmo_polls",   obs_poll_cnt, 4);
        check("tmo_ss_clr",  obs_ss_last, 32'h0);
        check("tmo_pslverr", {31'h0, obs_pslverr}, 1);

        // Slave error on the divider write
        plan_xip(32'h3000_0300, 32'h0bad_0bad, 0, 2);
        apb_xfer(32'h3000_0300, 32'h0, 1'b0, 4'h0);
        check("div_err_ctrl",    obs_ctrl_wr, 0);
        check("div_err_wb_cnt",  obs_wb_cnt, 3);
        check("div_err_pslverr", {31'h0, obs_pslverr}, 1);

        // Window edges
        plan_reject();
        apb_xfer(32'h2fff_ffff, 32'h0, 1'b0, 4'h0);
        check("below_flash_pslverr", {31'h0, obs_pslverr}, 1);
        plan_reject();
        apb_xfer(32'h1000_2000, 32'h0, 1'b0, 4'h0);
        check("above_spi_pslverr", {31'h0, obs_pslverr}, 1);
        plan_pass(32'h1000_1fff, 32'h0, 1'b0, 4'h3, 1'b0);
        apb_xfer(32'h1000_1fff, 32'h0, 1'b0, 4'h3);
        check("spi_end_adr", obs_last_adr, 32'h1f);
        plan_xip(32'h3fff_ffff, 32'ha1b2_c3d4, 0, -1);
        apb_xfer(32'h3fff_ffff, 32'h0, 1'b0, 4'h0);
        check("flash_end_prdata", obs_prdata, 32'hd4c3_b2a1);

        // Reset while polling
        plan_xip(32'h3000_0040, $urandom, 3, -1);
        @(negedge clock);
        in_paddr = 32'h3000_0040; in_pwrite = 1'b0; in_psel = 1'b1; in_penable = 1'b0;
        @(negedge clock);
        in_penable = 1'b1;
        exp_pending = 1'b1;
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(negedge clock);
            if (wb_cyc_o && wb_adr_o == 5'h10 && !wb_we_o) found = 1;
        end
        check("reach_poll", found, 1);
        #2;
        exp_pending = 1'b0;
        reset = 1'b1;
        #1;
        check("mid_rst_pready",  {31'h0, in_pready}, 0);
        check("mid_rst_prdata",  in_prdata, 0);
        check("mid_rst_pslverr", {31'h0, in_pslverr}, 0);
        check("mid_rst_adr",     {27'h0, wb_adr_o}, 0);
        check("mid_rst_dat",     wb_dat_o, 0);
        check("mid_rst_sel",     {28'h0, wb_sel_o}, 0);
        check("mid_rst_we",      {31'h0, wb_we_o}, 0);
        check("mid_rst_stb",     {31'h0, wb_stb_o}, 0);
        check("mid_rst_cyc",     {31'h0, wb_cyc_o}, 0);
        in_psel = 1'b0; in_penable = 1'b0;
        repeat (3) @(negedge clock);
        script.delete();
        reset = 1'b0;
        plan_xip(32'h3000_0080, 32'h5566_7788, 2, -1);
        apb_xfer(32'h3000_0080, 32'h0, 1'b0, 4'h0);
        check("after_rst_pslverr", {31'h0, obs_pslverr}, 0);
        check("after_rst_prdata",  obs_prdata, 32'h8877_6655);

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 5);
            d = $urandom;
            case (kind)
                0, 1: begin
                    a = 32'h1000_1000 + $urandom_range(0, 32'hfff);
                    w = {31'h0, kind == 0};
                    plan_pass(a, d, w[0], 4'($urandom), ($urandom_range(0, 7) == 0));
                    apb_xfer(a, d, w[0], script[0].sel);
                end
                2, 3: begin
                    a = 32'h3000_0000 | ($urandom & 32'h0fff_ffff);
                    plan_xip(a, d, $urandom_range(0, 5),
                             ($urandom_range(0, 4) == 0) ? $urandom_range(0, 12) : -1);
                    apb_xfer(a, 32'h0, 1'b0, 4'h0);
                end
                4: begin
                    a = 32'h3000_0000 | ($urandom & 32'h0fff_ffff);
                    plan_reject();
                    apb_xfer(a, d, 1'b1, 4'hf);
                end
                default: begin
                    a = $urandom;
                    for (int k = 0; k < 20 && in_window(a); k++) a = $urandom;
                    if (in_window(a)) a = 32'h0000_0100;
                    plan_reject();
                    apb_xfer(a, d, $urandom_range(0, 1) == 1, 4'hf);
                end
            endcase
        end

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_xip_ctrl.md
SPI_XIP_CTRL -- requirements
Module: spi_xip_ctrl

Interface
REQ-001 Parameter FLASH_BASE, default 32'h30000000: lowest XIP flash address.
REQ-002 Parameter FLASH_END, default 32'h3fffffff: highest XIP flash address.
REQ-003 Parameter SPI_BASE, default 32'h10001000: lowest SPI-master register address.
REQ-004 Parameter SPI_END, default 32'h10001fff: highest SPI-master register address.
REQ-005 Parameter DIVIDER, default 32'h1: SCK divider written per XIP read.
REQ-006 Parameter SS_MASK, default 8'h01: flash slave-select bit.
REQ-007 Parameter POLL_MAX, default 1024: maximum CTRL polls per XIP read.
REQ-008 Ports (one clock; reset asynchronous, active-high):
  clock  in  1  sole clock
  reset  in  1  asynchronous, active-high
  in_paddr  in  32  APB address
  in_psel  in  1  APB select
  in_penable  in  1  APB access phase
  in_pwrite  in  1  APB write
  in_pwdata  in  32  APB write data
  in_pstrb  in  4  APB byte strobes
  in_pready  out  1  APB completion pulse
  in_prdata  out  32  APB read data
  in_pslverr  out  1  APB error, valid with in_pready
  wb_adr_o  out  5  SPI-master register offset
  wb_dat_o  out  32  Wishbone write data
  wb_dat_i  in  32  Wishbone read data
  wb_sel_o  out  4  Wishbone byte selects
  wb_we_o  out  1  Wishbone write enable
  wb_stb_o  out  1  Wishbone strobe
  wb_cyc_o  out  1  Wishbone cycle
  wb_ack_i  in  1  Wishbone acknowledge
  wb_err_i  in  1  Wishbone error

Function
REQ-009 FSM states: IDLE, PASS, W_TX1, W_TX0, W_DIV, W_SS, W_CTRL, POLL, RD_RX, CLR_SS, RESP.
REQ-010 IDLE SHALL accept a request only when in_psel && in_penable; address and data are latched on acceptance.
REQ-011 An address in SPI_BASE..SPI_END SHALL go to PASS: one Wishbone cycle with adr=paddr[4:0], data/sel/we from APB.
REQ-012 An XIP read SHALL sequence W_TX1 (0x04 <= {8'h03, paddr[23:0]}), W_TX0 (0x00 <= 0), W_DIV (0x14 <= DIVIDER), W_SS (0x18 <= SS_MASK), then W_CTRL (0x10 <= 32'h2140: ASS, GO_BSY, CHAR_LEN=64).
REQ-013 Each Wishbone step SHALL hold cyc/stb with sel=4'hf until wb_ack_i, drop cyc/stb the cycle after ack, and advance; no step may be skipped.
REQ-014 POLL SHALL read 0x10 repeatedly and advance to RD_RX on the first ack with wb_dat_i[8]==0.
REQ-015 RD_RX SHALL read 0x00 and latch the byte-swapped value {d[7:0], d[15:8], d[23:16], d[31:24]} as read data.
REQ-016 CLR_SS SHALL write 0x18 <= 0 before every XIP response, including error paths taken after W_SS.
REQ-017 RESP SHALL assert in_pready for exactly one cycle and then return to IDLE.
REQ-018 In RESP, in_prdata SHALL be the latched data and in_pslverr the latched error flag; outside RESP both SHALL be 0.
REQ-019 An XIP write, or an address outside both windows, SHALL go directly to RESP with in_pslverr=1 and no Wishbone traffic.
REQ-020 wb_err_i during any step SHALL abort the sequence (via CLR_SS if W_SS was completed) and respond with in_pslverr=1.
REQ-021 When POLL_MAX polls elapse with bit 8 still set, the block SHALL go to CLR_SS and respond with in_pslverr=1.
REQ-022 At most one transaction SHALL be outstanding; APB requests arriving during a sequence are ignored until RESP completes.

Reset
REQ-023 Reset SHALL force state=IDLE and drive every output to 0: in_pready, in_prdata, in_pslverr, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o.
REQ-024 Reset mid-sequence SHALL abandon the transaction with no in_pready pulse.

Structure
REQ-025 A shared package spi_xip_pkg SHALL hold the register offsets (RX0, TX0, TX1, CTRL, DIVIDER, SS), the read opcode 8'h03, the CTRL word and the state enum.
REQ-026 The block SHALL be a single FSM with a poll counter; no sub-module is needed.

Verification
REQ-027 XIP read 0x30000104 with flash word 0x11223344 -> TX1 write 0x03000104, prdata 0x44332211, pslverr=0, SS cleared to 0.
REQ-028 APB write 0x10001014 data 0x5 -> single Wishbone write adr 0x14 data 0x5; pready on the cycle after ack.
REQ-029 APB write 0x30000000 -> pready with pslverr=1 on the next cycle, no cyc asserted.
REQ-030 CTRL bit 8 stuck at 1 with POLL_MAX=4 -> 4 polls, SS write 0, pslverr=1.
REQ-031 wb_err_i asserted during W_DIV -> abort, pslverr=1, no CTRL write.
REQ-032 Reset asserted during POLL -> all outputs 0 immediately, no pready; the next XIP read succeeds.
